port_bridge: RTL and testbench

//  Peripheral-side endpoint of the register file's bidirectional PORT bus.
//  - Buffers CPU port writes (register file SEL = port-write) in a TX FIFO.
//  - Drains the FIFO to an external device over a valid/ready link.
//  - Captures inbound bytes from the device into one RX holding register.
//  - Drives that byte onto PORT when the CPU reads the port (SEL = port-read).

---
 rtl/port_bridge_pkg.sv | 17 +
 rtl/port_bridge_if.sv | 26 ++
 rtl/port_bridge_sync_fifo.sv | 57 +++++
 rtl/port_bridge.sv | 92 +++++++++
 tb/tb_port_bridge.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/port_bridge_pkg.sv
// rtl/port_bridge_pkg.sv - shared widths, port select codes and RX FSM encodings
package port_bridge_pkg;

    localparam int DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        SEL_NONE    = 2'b00,
        SEL_PORT_RD = 2'b01,
        SEL_PORT_WR = 2'b10
    } port_sel_e;

    typedef enum logic {
        RX_EMPTY = 1'b0,
        RX_FULL  = 1'b1
    } rx_state_e;

endpackage

// File: rtl/port_bridge_if.sv
// rtl/port_bridge_if.sv - CPU port strobes plus device TX/RX link and status flags
interface port_bridge_if #(
    parameter int WIDTH = 8
);
    logic             port_wr;
    logic             port_rd;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             tx_full;
    logic             tx_ovf;
    logic             rx_avail;

    modport master (
        input  port_wr, port_rd, tx_ready, rx_data, rx_valid,
        output tx_data, tx_valid, rx_ready, tx_full, tx_ovf, rx_avail
    );

    modport slave (
        output port_wr, port_rd, tx_ready, rx_data, rx_valid,
        input  tx_data, tx_valid, rx_ready, tx_full, tx_ovf, rx_avail
    );
endinterface

// File: rtl/port_bridge_sync_fifo.sv
// rtl/port_bridge_sync_fifo.sv - single-clock FIFO with combinational head read
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

endmodule

// File: rtl/port_bridge.sv
// rtl/port_bridge.sv - PORT bus endpoint: TX FIFO toward the device, RX holding register toward the CPU
module port_bridge
    import port_bridge_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire [WIDTH-1:0]  port,
    port_bridge_if.master    bus
);
    port_sel_e        sel;
    rx_state_e        state_q;
    rx_state_e        state_d;
    logic [WIDTH-1:0] hold;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             capture;

    // A simultaneous read and write is a write: the register file owns the bus.
    always_comb begin
        sel = SEL_NONE;
        if (bus.port_wr) begin
            sel = SEL_PORT_WR;
        end else if (bus.port_rd) begin
            sel = SEL_PORT_RD;
        end
    end

    assign pop = bus.tx_valid & bus.tx_ready;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (sel == SEL_PORT_WR),
        .pop   (pop),
        .din   (port),
        .dout  (bus.tx_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.tx_valid = ~fifo_empty;
    assign bus.tx_full  = fifo_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.tx_ovf <= 1'b0;
        end else if ((sel == SEL_PORT_WR) && fifo_full && !pop) begin
            bus.tx_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RX_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_EMPTY: if (bus.rx_valid)        state_d = RX_FULL;
            RX_FULL:  if (sel == SEL_PORT_RD)  state_d = RX_EMPTY;
            default:                           state_d = RX_EMPTY;
        endcase
    end

    always_comb begin
        bus.rx_ready = (state_q == RX_EMPTY) && !rst;
        bus.rx_avail = (state_q == RX_FULL);
        capture      = bus.rx_ready & bus.rx_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold <= '0;
        end else if (capture) begin
            hold <= bus.rx_data;
        end
    end

    assign port = ((sel == SEL_PORT_RD) && !rst) ? hold : {WIDTH{1'bz}};

endmodule

// File: tb/tb_port_bridge.sv
// tb/tb_port_bridge.sv - directed self-checking bench for port_bridge
module tb_port_bridge;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] drv_val;
    logic       drv_en;
    wire  [7:0] port;
    int         passed = 0;
    int         total  = 0;

    port_bridge_if #(.WIDTH(8)) bus ();

    port_bridge #(.WIDTH(8), .DEPTH(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .port (port),
        .bus  (bus)
    );

    assign port = drv_en ? drv_val : 8'bz;

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.rx_valid = 1'b1; bus.rx_data = 8'h33;
        bus.port_wr = 1'b1; bus.port_rd = 1'b0; bus.tx_ready = 1'b0;
        drv_en = 1'b1; drv_val = 8'h99;
        step(); step();
        total++; if (bus.tx_valid !== 1'b0) $display("FAIL reset_tx_valid got %b exp 0", bus.tx_valid); else passed++;
        total++; if (bus.rx_ready !== 1'b0) $display("FAIL reset_rx_ready got %b exp 0", bus.rx_ready); else passed++;
        total++; if (bus.rx_avail !== 1'b0) $display("FAIL reset_rx_avail got %b exp 0", bus.rx_avail); else passed++;
        total++; if (bus.tx_ovf !== 1'b0) $display("FAIL reset_tx_ovf got %b exp 0", bus.tx_ovf); else passed++;
        total++; if (bus.tx_full !== 1'b0) $display("FAIL reset_tx_full got %b exp 0", bus.tx_full); else passed++;
        total++; if (port !== 8'h99) $display("FAIL reset_port_released got %h exp 99", port); else passed++;
        rst = 1'b0; bus.rx_valid = 1'b0; bus.port_wr = 1'b0; drv_en = 1'b0;
        step();
        total++; if (bus.rx_ready !== 1'b1) $display("FAIL post_reset_rx_ready got %b exp 1", bus.rx_ready); else passed++;
        total++; if (bus.tx_valid !== 1'b0) $display("FAIL post_reset_tx_valid got %b exp 0", bus.tx_valid); else passed++;
    endtask

    task automatic pulse_reset();
        rst = 1'b1; step(); rst = 1'b0;
    endtask

    task automatic test_tx_fill_drain();
        logic [7:0] vals [4] = '{8'hDE, 8'hAB, 8'h12, 8'h34};
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.port_wr = 1'b1; drv_en = 1'b1; drv_val = vals[i];
            step();
        end
        total++; if (bus.tx_full !== 1'b1) $display("FAIL fill_full got %b exp 1", bus.tx_full); else passed++;
        total++; if (bus.tx_data !== 8'hDE) $display("FAIL fill_head got %h exp de", bus.tx_data); else passed++;
        total++; if (bus.tx_ovf !== 1'b0) $display("FAIL fill_no_ovf got %b exp 0", bus.tx_ovf); else passed++;
        drv_val = 8'h56;
        step();
        total++; if (bus.tx_ovf !== 1'b1) $display("FAIL drop_ovf got %b exp 1", bus.tx_ovf); else passed++;
        total++; if (bus.tx_data !== 8'hDE) $display("FAIL drop_head got %h exp de", bus.tx_data); else passed++;
        bus.port_wr = 1'b0; drv_en = 1'b0; bus.tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== vals[i])
                $display("FAIL drain_%0d got v=%b d=%h exp v=1 d=%h", i, bus.tx_valid, bus.tx_data, vals[i]); else passed++;
            step();
        end
        total++; if (bus.tx_valid !== 1'b0) $display("FAIL drain_empty got %b exp 0", bus.tx_valid); else passed++;
        total++; if (bus.tx_ovf !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", bus.tx_ovf); else passed++;
        bus.tx_ready = 1'b0;
    endtask

    task automatic test_push_pop_full();
        logic [7:0] exp_q [4] = '{8'h02, 8'h03, 8'h04, 8'hDC};
        pulse_reset();
        for (int i = 1; i <= 4; i++) begin
            bus.port_wr = 1'b1; drv_en = 1'b1; drv_val = 8'(i);
            step();
        end
        bus.tx_ready = 1'b1; drv_val = 8'hDC;
        step();
        bus.port_wr = 1'b0; drv_en = 1'b0;
        total++; if (bus.tx_full !== 1'b1) $display("FAIL pp_full got %b exp 1", bus.tx_full); else passed++;
        total++; if (bus.tx_ovf !== 1'b0) $display("FAIL pp_no_ovf got %b exp 0", bus.tx_ovf); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp_q[i])
                $display("FAIL pp_drain_%0d got v=%b d=%h exp v=1 d=%h", i, bus.tx_valid, bus.tx_data, exp_q[i]); else passed++;
            step();
        end
        total++; if (bus.tx_valid !== 1'b0) $display("FAIL pp_empty got %b exp 0", bus.tx_valid); else passed++;
        bus.tx_ready = 1'b0;
    endtask

    task automatic test_rx();
        bus.rx_valid = 1'b1; bus.rx_data = 8'hAC;
        step();
        total++; if (bus.rx_avail !== 1'b1 || bus.rx_ready !== 1'b0)
            $display("FAIL rx_capture got avail=%b ready=%b exp 1/0", bus.rx_avail, bus.rx_ready); else passed++;
        bus.rx_data = 8'h55;
        step();
        drv_en = 1'b1; drv_val = 8'h00;
        #1;
        total++; if (port !== 8'h00) $display("FAIL rx_idle_release got %h exp 00", port); else passed++;
        drv_en = 1'b0; bus.port_rd = 1'b1;
        #1;
        total++; if (port !== 8'hAC) $display("FAIL rx_read_first got %h exp ac", port); else passed++;
        step();
        bus.port_rd = 1'b0;
        total++; if (bus.rx_avail !== 1'b0 || bus.rx_ready !== 1'b1)
            $display("FAIL rx_consume got avail=%b ready=%b exp 0/1", bus.rx_avail, bus.rx_ready); else passed++;
        step();
        bus.rx_valid = 1'b0;
        total++; if (bus.rx_avail !== 1'b1) $display("FAIL rx_second_capture got %b exp 1", bus.rx_avail); else passed++;
        bus.port_rd = 1'b1;
        #1;
        total++; if (port !== 8'h55) $display("FAIL rx_read_second got %h exp 55", port); else passed++;
        bus.port_rd = 1'b0;
        #1;
    endtask

    task automatic test_rd_wr_collision();
        bus.port_rd = 1'b1; bus.port_wr = 1'b1; drv_en = 1'b1; drv_val = 8'hDC;
        #1;
        total++; if (port !== 8'hDC) $display("FAIL coll_port got %h exp dc", port); else passed++;
        step();
        bus.port_rd = 1'b0; bus.port_wr = 1'b0; drv_en = 1'b0;
        total++; if (bus.rx_avail !== 1'b1) $display("FAIL coll_rx_kept got %b exp 1", bus.rx_avail); else passed++;
        total++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hDC)
            $display("FAIL coll_pushed got v=%b d=%h exp v=1 d=dc", bus.tx_valid, bus.tx_data); else passed++;
    endtask

    task automatic test_reset_mid();
        bus.port_wr = 1'b1; drv_en = 1'b1; drv_val = 8'h11;
        step();
        bus.port_wr = 1'b0; drv_en = 1'b0;
        rst = 1'b1; bus.tx_ready = 1'b1;
        step();
        rst = 1'b0; bus.tx_ready = 1'b0;
        total++; if (bus.tx_valid !== 1'b0 || bus.tx_full !== 1'b0)
            $display("FAIL mid_fifo_empty got v=%b f=%b exp 0/0", bus.tx_valid, bus.tx_full); else passed++;
        total++; if (bus.rx_avail !== 1'b0) $display("FAIL mid_rx_lost got %b exp 0", bus.rx_avail); else passed++;
        total++; if (bus.tx_ovf !== 1'b0) $display("FAIL mid_ovf got %b exp 0", bus.tx_ovf); else passed++;
        bus.port_wr = 1'b1; drv_en = 1'b1; drv_val = 8'h77;
        #1;
        total++; if (bus.tx_valid !== 1'b0) $display("FAIL no_bypass got %b exp 0", bus.tx_valid); else passed++;
        step();
        bus.port_wr = 1'b0; drv_en = 1'b0;
        total++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h77)
            $display("FAIL mid_push got v=%b d=%h exp v=1 d=77", bus.tx_valid, bus.tx_data); else passed++;
    endtask

    initial begin
        test_reset();
        test_tx_fill_drain();
        test_push_pop_full();
        test_rx();
        test_rd_wr_collision();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
